light_transition_sequencer: RTL and testbench

LIGHT_TRANSITION_SEQUENCER -- requirements
Module: light_transition_sequencer

---
 rtl/light_transition_sequencer.sv | 117 +++++++++++
 tb/tb_light_transition_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/light_transition_sequencer.sv
// Lane lamp sequencer: newly added lanes go green at once, while dropped lanes
// go yellow, then all-red clearance, before the latched new set goes green.
module light_transition_sequencer #(
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2,
    parameter int MAX_GREEN   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] target,
    output logic [7:0] green,
    output logic [7:0] yellow,
    output logic [7:0] red,
    output logic       busy,
    output logic       fault
);

    typedef enum logic [1:0] {STEADY, YELLOW, CLEAR} state_t;

    localparam logic [6:0] YT_LOAD = 7'(YELLOW_TIME - 1);
    localparam logic [6:0] AR_LOAD = 7'(ALLRED_TIME - 1);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cur, w_cur_nxt;
    logic [7:0] r_pend, w_pend_nxt;
    logic [6:0] r_cnt, w_cnt_nxt;
    logic       r_fault;
    logic [3:0] w_pop;
    logic       w_illegal;
    logic [7:0] w_eff;
    logic [7:0] w_green_nxt, w_yellow_nxt;

    always_comb begin
        w_pop = 4'd0;
        for (int i = 0; i < 8; i++) w_pop = w_pop + {3'd0, target[i]};
    end

    assign w_illegal = (w_pop > 4'(MAX_GREEN));
    assign w_eff     = w_illegal ? 8'h00 : target;

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_pend_nxt  = r_pend;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            STEADY: begin
                if ((r_cur & ~w_eff) != 8'h00) begin
                    w_pend_nxt  = w_eff;
                    w_cnt_nxt   = YT_LOAD;
                    w_state_nxt = YELLOW;
                end else begin
                    w_cur_nxt = w_eff;
                end
            end
            YELLOW: begin
                if (r_cnt == 7'd0) begin
                    w_cnt_nxt   = AR_LOAD;
                    w_state_nxt = CLEAR;
                end else begin
                    w_cnt_nxt = r_cnt - 7'd1;
                end
            end
            CLEAR: begin
                if (r_cnt == 7'd0) begin
                    w_cur_nxt   = r_pend;
                    w_state_nxt = STEADY;
                end else begin
                    w_cnt_nxt = r_cnt - 7'd1;
                end
            end
            default: w_state_nxt = STEADY;
        endcase
    end

    // Lamps are computed from next-state values so the registered outputs
    // track the post-edge state without an extra cycle of lag.
    always_comb begin
        w_green_nxt  = w_cur_nxt;
        w_yellow_nxt = 8'h00;
        case (w_state_nxt)
            YELLOW: begin
                w_green_nxt  = w_cur_nxt & w_pend_nxt;
                w_yellow_nxt = w_cur_nxt & ~w_pend_nxt;
            end
            CLEAR:   w_green_nxt = w_cur_nxt & w_pend_nxt;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= STEADY;
            r_cur   <= 8'h00;
            r_pend  <= 8'h00;
            r_cnt   <= 7'd0;
            r_fault <= 1'b0;
            green   <= 8'h00;
            yellow  <= 8'h00;
            red     <= 8'hFF;
            busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_pend  <= w_pend_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fault <= r_fault | w_illegal;
            green   <= w_green_nxt;
            yellow  <= w_yellow_nxt;
            red     <= ~(w_green_nxt | w_yellow_nxt);
            busy    <= (w_state_nxt != STEADY);
        end
    end

    assign fault = r_fault;

endmodule

// File: tb/tb_light_transition_sequencer.sv
// Directed bench for light_transition_sequencer with default timing parameters.
module tb_light_transition_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] target;
    logic [7:0] green, yellow, red;
    logic       busy, fault;

    int errors = 0;
    int checks = 0;

    light_transition_sequencer dut (
        .clk(clk), .rst(rst), .target(target),
        .green(green), .yellow(yellow), .red(red),
        .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        target = 8'h00;
        step(2);
        checks++;
        if ({green, yellow, red, busy, fault} !== {8'h00, 8'h00, 8'hFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: g=%h y=%h r=%h busy=%b fault=%b, want 00 00 ff 0 0",
                     green, yellow, red, busy, fault);
        end
        rst = 1'b1;
        step(1);
    endtask

    task automatic test_add;
        target = 8'h11;
        step(1);
        checks++;
        if ({green, yellow, red, busy} !== {8'h11, 8'h00, 8'hEE, 1'b0}) begin
            errors++;
            $display("FAIL add: g=%h y=%h r=%h busy=%b, want 11 00 ee 0", green, yellow, red, busy);
        end
    endtask

    task automatic test_drop;
        target = 8'h22;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++;
            if ({green, yellow, red, busy} !== {8'h00, 8'h11, 8'hEE, 1'b1}) begin
                errors++;
                $display("FAIL drop_yellow[%0d]: g=%h y=%h r=%h busy=%b, want 00 11 ee 1",
                         i, green, yellow, red, busy);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1);
            checks++;
            if ({green, yellow, red, busy} !== {8'h00, 8'h00, 8'hFF, 1'b1}) begin
                errors++;
                $display("FAIL drop_clear[%0d]: g=%h y=%h r=%h busy=%b, want 00 00 ff 1",
                         i, green, yellow, red, busy);
            end
        end
        step(1);
        checks++;
        if ({green, yellow, red, busy} !== {8'h22, 8'h00, 8'hDD, 1'b0}) begin
            errors++;
            $display("FAIL drop_done: g=%h y=%h r=%h busy=%b, want 22 00 dd 0", green, yellow, red, busy);
        end
    endtask

    task automatic test_partial;
        target = 8'h03;
        step(6);
        checks++;
        if ({green, busy} !== {8'h03, 1'b0}) begin
            errors++;
            $display("FAIL partial_setup: g=%h busy=%b, want 03 0", green, busy);
        end
        target = 8'h01;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++;
            if ({green, yellow, red, busy} !== {8'h01, 8'h02, 8'hFC, 1'b1}) begin
                errors++;
                $display("FAIL partial_yellow[%0d]: g=%h y=%h r=%h busy=%b, want 01 02 fc 1",
                         i, green, yellow, red, busy);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1);
            checks++;
            if ({green, yellow, red, busy} !== {8'h01, 8'h00, 8'hFE, 1'b1}) begin
                errors++;
                $display("FAIL partial_clear[%0d]: g=%h y=%h r=%h busy=%b, want 01 00 fe 1",
                         i, green, yellow, red, busy);
            end
        end
        step(1);
        checks++;
        if ({green, yellow, red, busy} !== {8'h01, 8'h00, 8'hFE, 1'b0}) begin
            errors++;
            $display("FAIL partial_done: g=%h y=%h r=%h busy=%b, want 01 00 fe 0", green, yellow, red, busy);
        end
    endtask

    task automatic test_fault;
        target = 8'h11;
        step(1);
        checks++;
        if ({green, fault} !== {8'h11, 1'b0}) begin
            errors++;
            $display("FAIL fault_setup: g=%h fault=%b, want 11 0", green, fault);
        end
        target = 8'h1F;
        step(1);
        checks++;
        if ({green, yellow, busy, fault} !== {8'h00, 8'h11, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL fault_flag: g=%h y=%h busy=%b fault=%b, want 00 11 1 1", green, yellow, busy, fault);
        end
        step(5);
        checks++;
        if ({green, yellow, red, busy, fault} !== {8'h00, 8'h00, 8'hFF, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL fault_dark: g=%h y=%h r=%h busy=%b fault=%b, want 00 00 ff 0 1",
                     green, yellow, red, busy, fault);
        end
        target = 8'h11;
        step(1);
        checks++;
        if ({green, red, busy, fault} !== {8'h11, 8'hEE, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL fault_sticky: g=%h r=%h busy=%b fault=%b, want 11 ee 0 1", green, red, busy, fault);
        end
    endtask

    task automatic test_ignore;
        target = 8'h22;
        step(1);
        target = 8'h44;
        step(2);
        checks++;
        if ({green, yellow, busy} !== {8'h00, 8'h11, 1'b1}) begin
            errors++;
            $display("FAIL ignore_yellow: g=%h y=%h busy=%b, want 00 11 1", green, yellow, busy);
        end
        step(3);
        checks++;
        if ({green, yellow, busy} !== {8'h22, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL ignore_done: g=%h y=%h busy=%b, want 22 00 0", green, yellow, busy);
        end
        step(1);
        checks++;
        if ({green, yellow, busy} !== {8'h00, 8'h22, 1'b1}) begin
            errors++;
            $display("FAIL ignore_restart: g=%h y=%h busy=%b, want 00 22 1", green, yellow, busy);
        end
        step(5);
        checks++;
        if ({green, red, busy} !== {8'h44, 8'hBB, 1'b0}) begin
            errors++;
            $display("FAIL ignore_final: g=%h r=%h busy=%b, want 44 bb 0", green, red, busy);
        end
    endtask

    task automatic test_reset_mid;
        target = 8'h88;
        step(4);
        checks++;
        if ({green, yellow, red, busy} !== {8'h00, 8'h00, 8'hFF, 1'b1}) begin
            errors++;
            $display("FAIL mid_clear: g=%h y=%h r=%h busy=%b, want 00 00 ff 1", green, yellow, red, busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({green, yellow, red, busy, fault} !== {8'h00, 8'h00, 8'hFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: g=%h y=%h r=%h busy=%b fault=%b, want 00 00 ff 0 0",
                     green, yellow, red, busy, fault);
        end
        step(1);
        rst = 1'b1;
        step(1);
        checks++;
        if ({green, yellow, red, busy} !== {8'h88, 8'h00, 8'h77, 1'b0}) begin
            errors++;
            $display("FAIL mid_after: g=%h y=%h r=%h busy=%b, want 88 00 77 0", green, yellow, red, busy);
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_drop;
        test_partial;
        test_fault;
        test_ignore;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
